// File: rtl/iaoq_pkg.sv
// Shared definitions for the instruction address offset queue update logic.
package iaoq_pkg;

  typedef enum logic {
    RUN       = 1'b0,
    NULL_SLOT = 1'b1
  } iaoq_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/iaoq_update_null_ctrl.sv
// Effective-branch and delay-slot nullification decode for the instruction at IAOQ_FRONT.
module null_ctrl (
  input  logic nullify,
  input  logic bl,
  input  logic comb,
  input  logic cond_true,
  input  logic n_bit,
  input  logic disp_neg,
  output logic br,
  output logic nxt_null
);

  // A nullified instruction neither branches nor nullifies its successor; BL wins over COMB.
  always_comb begin
    br       = 1'b0;
    nxt_null = 1'b0;
    if (!nullify) begin
      br = bl | (comb & cond_true);
      if (bl) begin
        nxt_null = n_bit;
      end else if (comb) begin
        // forward-taken or backward-not-taken squashes the delay slot
        nxt_null = n_bit & (cond_true ^ disp_neg);
      end else begin
        nxt_null = 1'b0;
      end
    end else begin
      br       = 1'b0;
      nxt_null = 1'b0;
    end
  end

endmodule

// File: rtl/iaoq_update.sv
// PA-RISC IAOQ front/back registers with branch redirect, nullification and taken counter.
module iaoq_update
  import iaoq_pkg::*;
#(
  parameter logic [31:0] RESET_FRONT = 32'h0000_0000,
  parameter logic [31:0] RESET_BACK  = 32'h0000_0004,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LE,
  input  logic             BL,
  input  logic             COMB,
  input  logic             COND_TRUE,
  input  logic             N_BIT,
  input  logic             DISP_NEG,
  input  logic [31:0]      TA,
  output logic [31:0]      IAOQ_FRONT,
  output logic [31:0]      IAOQ_BACK,
  output logic             NULLIFY,
  output logic [31:0]      LINK_ADDR,
  output logic             BR_TAKEN,
  output logic [CNT_W-1:0] TAKEN_CNT
);

  iaoq_state_e      state_r, state_nxt_s;
  logic [31:0]      front_r, back_r, front_nxt_s, back_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             br_s, nxt_null_s;

  null_ctrl u_null_ctrl (
    .nullify   (state_r == NULL_SLOT),
    .bl        (BL),
    .comb      (COMB),
    .cond_true (COND_TRUE),
    .n_bit     (N_BIT),
    .disp_neg  (DISP_NEG),
    .br        (br_s),
    .nxt_null  (nxt_null_s)
  );

  // Next-state for the queue, nullify state and saturating counter; stall holds everything.
  always_comb begin
    state_nxt_s = state_r;
    front_nxt_s = front_r;
    back_nxt_s  = back_r;
    cnt_nxt_s   = cnt_r;
    if (LE) begin
      state_nxt_s = nxt_null_s ? NULL_SLOT : RUN;
      front_nxt_s = back_r;
      back_nxt_s  = br_s ? TA : (back_r + INSTR_BYTES);
      if (br_s && !(&cnt_r)) begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      front_r <= RESET_FRONT;
      back_r  <= RESET_BACK;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      front_r <= front_nxt_s;
      back_r  <= back_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign IAOQ_FRONT = front_r;
  assign IAOQ_BACK  = back_r;
  assign NULLIFY    = (state_r == NULL_SLOT);
  assign TAKEN_CNT  = cnt_r;
  assign BR_TAKEN   = br_s;
  assign LINK_ADDR  = front_r + 32'd8;

endmodule

// File: tb/tb_iaoq_update.sv
// Directed scoreboard bench for iaoq_update, plus a narrow-counter instance for saturation.
module tb_iaoq_update;

  typedef struct {
    string       tag;
    logic [31:0] front;
    logic [31:0] back;
    logic        nul;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        le = 1'b0, bl = 1'b0, comb = 1'b0, cond_true = 1'b0, n_bit = 1'b0, disp_neg = 1'b0;
  logic [31:0] ta = 32'h0;
  logic [31:0] front, back, link_addr;
  logic        nullify, br_taken;
  logic [15:0] taken_cnt;

  logic        s_le = 1'b0, s_bl = 1'b0;
  logic [31:0] s_front, s_back, s_link;
  logic        s_null, s_br;
  logic [1:0]  s_cnt;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_front = 32'h0;

  always #5 clk = ~clk;

  iaoq_update dut (
    .clk(clk), .reset(reset), .LE(le), .BL(bl), .COMB(comb), .COND_TRUE(cond_true),
    .N_BIT(n_bit), .DISP_NEG(disp_neg), .TA(ta), .IAOQ_FRONT(front), .IAOQ_BACK(back),
    .NULLIFY(nullify), .LINK_ADDR(link_addr), .BR_TAKEN(br_taken), .TAKEN_CNT(taken_cnt)
  );

  iaoq_update #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .LE(s_le), .BL(s_bl), .COMB(1'b0), .COND_TRUE(1'b0),
    .N_BIT(1'b0), .DISP_NEG(1'b0), .TA(32'h0000_0040), .IAOQ_FRONT(s_front), .IAOQ_BACK(s_back),
    .NULLIFY(s_null), .LINK_ADDR(s_link), .BR_TAKEN(s_br), .TAKEN_CNT(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] ef, input logic [31:0] eb,
                          input logic en, input logic [15:0] ec);
    chk({tag, ".front"}, front, ef);
    chk({tag, ".back"}, back, eb);
    chk({tag, ".null"}, {31'd0, nullify}, {31'd0, en});
    chk({tag, ".cnt"}, {16'd0, taken_cnt}, {16'd0, ec});
  endtask

  // Drive one cycle's inputs, check combinational outputs, clock, then check registered result.
  task automatic cycle(input string tag, input logic i_le, input logic i_bl, input logic i_comb,
                       input logic i_ct, input logic i_n, input logic i_dn, input logic [31:0] i_ta,
                       input logic e_br, input logic [31:0] ef, input logic [31:0] eb,
                       input logic en, input logic [15:0] ec);
    exp_t e;
    le = i_le; bl = i_bl; comb = i_comb; cond_true = i_ct; n_bit = i_n; disp_neg = i_dn; ta = i_ta;
    e.tag = tag; e.front = ef; e.back = eb; e.nul = en; e.cnt = ec;
    sb_q.push_back(e);
    #1;
    chk({tag, ".br_taken"}, {31'd0, br_taken}, {31'd0, e_br});
    chk({tag, ".link"}, link_addr, cur_front + 32'd8);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_regs(e.tag, e.front, e.back, e.nul, e.cnt);
    cur_front = e.front;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_regs("reset", 32'h0, 32'h4, 1'b0, 16'd0);
    reset = 1'b0;

    // no-branch sequencing
    cycle("seq1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h4, 32'h8, 1'b0, 16'd0);
    cycle("seq2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h8, 32'hC, 1'b0, 16'd0);
    cycle("seq3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hC, 32'h10, 1'b0, 16'd0);
    for (int i = 1; i <= 61; i++) begin
      cycle("walk", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0,
            32'hC + 32'(i) * 32'd4, 32'h10 + 32'(i) * 32'd4, 1'b0, 16'd0);
    end

    // BL from 0x100 to 0x200, no nullify
    chk("bl.link_pre", link_addr, 32'h108);
    cycle("bl", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b1, 32'h104, 32'h200, 1'b0, 16'd1);
    cycle("bl_land", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h200, 32'h204, 1'b0, 16'd1);

    // COMB forward taken with n: slot nullified, a BL in the slot is ignored
    cycle("comb_fwd", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 32'h204, 32'h300, 1'b1, 16'd2);
    cycle("null_bl", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 1'b0, 32'h300, 32'h304, 1'b0, 16'd2);

    // COMB backward with n: not taken nullifies, taken does not
    cycle("comb_bk_nt", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h280, 1'b0, 32'h304, 32'h308, 1'b1, 16'd2);
    cycle("after_null", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h308, 32'h30C, 1'b0, 16'd2);
    cycle("comb_bk_t", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h2F0, 1'b1, 32'h30C, 32'h2F0, 1'b0, 16'd3);

    // stall with BL asserted holds everything
    for (int i = 0; i < 4; i++) begin
      cycle("stall", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 1'b1, 32'h30C, 32'h2F0, 1'b0, 16'd3);
    end

    // enter NULL_SLOT, stall there, then async reset
    cycle("bl_n", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h600, 1'b1, 32'h2F0, 32'h600, 1'b1, 16'd4);
    cycle("stall_null", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2F0, 32'h600, 1'b1, 16'd4);
    reset = 1'b1;
    #2;
    chk_regs("async_rst", 32'h0, 32'h4, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur_front = 32'h0;

    // address wrap
    cycle("to_top", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h4, 32'hFFFF_FFFC, 1'b0, 16'd1);
    cycle("wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 16'd1);
    cycle("post_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4, 1'b0, 16'd1);

    // 2-bit counter saturates at 3 after 5 taken branches
    s_le = 1'b1;
    s_bl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("sat_cnt", {30'd0, s_cnt}, (i < 2) ? 32'(i + 1) : 32'd3);
    end
    s_le = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
